// File: rtl/weight_buf_if.sv
// Load-stream and burst-read bus for weight_buf.
interface weight_buf_if #(
    parameter int WIDTH  = 64,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 4096
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [BYTE_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_len;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_last;
    logic              busy;

    modport master (
        output ld_start, ld_base, ld_len, ld_valid, ld_data,
        output rd_start, rd_base, rd_len,
        input  ld_ready, ld_done, rd_valid, rd_data, rd_last, busy
    );
    modport slave (
        input  ld_start, ld_base, ld_len, ld_valid, ld_data,
        input  rd_start, rd_base, rd_len,
        output ld_ready, ld_done, rd_valid, rd_data, rd_last, busy
    );
endinterface

// File: rtl/weight_buf.sv
// Weight buffer: packs a byte stream into wide words on load, streams
// word bursts on read through a two-stage (memory, output) read pipeline.
module weight_buf #(
    parameter int WIDTH  = 64,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    weight_buf_if.slave  bus
);
    localparam int BPW    = WIDTH / BYTE_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr, addr_inc;
    logic [ADDR_W:0]     len, wcnt;
    logic [BCNT_W-1:0]   bcnt;
    logic [WIDTH-1:0]    pack, pack_nx, mem_q, rd_data_q;
    logic [STAGES:1]     vld_pipe, last_pipe;
    logic                ld_done_q, last_d;
    logic                acc, word_wr, at_last, fin, busy_w, can_start;

    logic [WIDTH-1:0]    mem [DEPTH];

    generate
        if (BPW > 1) begin : g_pack
            assign pack_nx = {pack[WIDTH-BYTE_W-1:0], bus.ld_data};
        end else begin : g_nopack
            assign pack_nx = bus.ld_data;
        end
    endgenerate

    assign addr_inc  = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
    assign acc       = (state == LOAD) && bus.ld_valid;
    assign word_wr   = acc && (bcnt == BCNT_W'(BPW - 1));
    assign at_last   = (wcnt == len - (ADDR_W + 1)'(1));
    // busy covers the ld_done pulse, words in flight and the cycle after rd_last
    assign busy_w    = (state != IDLE) || ld_done_q || (|vld_pipe) || last_d;
    assign can_start = (state == IDLE) && !busy_w;

    assign bus.ld_ready = (state == LOAD);
    assign bus.ld_done  = ld_done_q;
    assign bus.rd_valid = vld_pipe[STAGES];
    assign bus.rd_last  = last_pipe[STAGES];
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_w;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fin      = 1'b0;
        case (state)
            IDLE: if (can_start) begin
                if (bus.ld_start && bus.ld_len != '0)      state_nx = LOAD;
                else if (bus.rd_start && bus.rd_len != '0) state_nx = READ;
            end
            LOAD: if (word_wr && at_last) begin
                state_nx = IDLE;
                fin      = 1'b1;
            end
            READ: if (at_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            len       <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            pack      <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            rd_data_q <= '0;
            ld_done_q <= 1'b0;
            last_d    <= 1'b0;
        end else begin
            ld_done_q <= fin;
            last_d    <= last_pipe[STAGES];
            vld_pipe  <= {vld_pipe[STAGES-1:1], state == READ};
            last_pipe <= {last_pipe[STAGES-1:1], (state == READ) && at_last};
            if (vld_pipe[STAGES-1]) rd_data_q <= mem_q;
            if (state == IDLE && state_nx == LOAD) begin
                addr <= bus.ld_base;
                len  <= bus.ld_len;
                wcnt <= '0;
                bcnt <= '0;
            end else if (state == IDLE && state_nx == READ) begin
                addr <= bus.rd_base;
                len  <= bus.rd_len;
                wcnt <= '0;
            end else if (acc) begin
                pack <= pack_nx;
                bcnt <= word_wr ? '0 : bcnt + BCNT_W'(1);
                if (word_wr) begin
                    wcnt <= wcnt + (ADDR_W + 1)'(1);
                    addr <= addr_inc;
                end
            end else if (state == READ) begin
                wcnt <= wcnt + (ADDR_W + 1)'(1);
                addr <= addr_inc;
            end
        end
    end

    // Single-port array, not reset; load and read modes never overlap.
    always_ff @(posedge clk) begin
        if (word_wr && !rst)   mem[addr] <= pack_nx;
        if (state == READ)     mem_q     <= mem[addr];
    end
endmodule

// File: tb/tb_weight_buf.sv
// Directed/random bench for weight_buf against an array model of the buffer.
module tb_weight_buf;
    localparam int WIDTH  = 64;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 16;
    localparam int BPW    = WIDTH / BYTE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_buf_if #(.WIDTH(WIDTH), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) bus ();
    weight_buf #(.WIDTH(WIDTH), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] got [$];
    logic [7:0]       bytes [$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_bytes(input int n, input bit counting);
        bytes.delete();
        for (int i = 0; i < n; i++) bytes.push_back(counting ? 8'(i + 1) : 8'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'd0);
        chk({tag, "_ld_done"},  64'(bus.ld_done),  64'd0);
        chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        chk({tag, "_rd_last"},  64'(bus.rd_last),  64'd0);
        chk({tag, "_busy"},     64'(bus.busy),     64'd0);
        chk({tag, "_rd_data"},  64'(bus.rd_data),  64'd0);
    endtask

    // rst_at < 0: complete load; otherwise assert reset after rst_at bytes
    task automatic do_load(input int base, input int len, input bit gaps,
                           input int rst_at, input bit both);
        int idx = 0;
        int cyc = 0;
        int lim = (rst_at >= 0) ? rst_at : len * BPW;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        bus.ld_start = 1'b1; bus.ld_base = 4'(base); bus.ld_len = 5'(len);
        bus.rd_start = both; bus.rd_base = '0; bus.rd_len = 5'd2;
        @(negedge clk);
        bus.ld_start = 1'b0;
        while (idx < lim && cyc < 2000) begin
            chk("ld_ready_in_load", 64'(bus.ld_ready), 64'd1);
            chk("busy_in_load",     64'(bus.busy),     64'd1);
            chk("rd_valid_in_load", 64'(bus.rd_valid), 64'd0);
            chk("ld_done_early",    64'(bus.ld_done),  64'd0);
            bus.ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.ld_data  = bytes[idx];
            bus.rd_start = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (bus.ld_valid) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.rd_start = 1'b0;
        chk("ld_bytes_accepted", 64'(idx), 64'(lim));
        for (int k = 0; k < idx / BPW; k++) begin
            w = '0;
            for (int b = 0; b < BPW; b++) w = (w << BYTE_W) | WIDTH'(bytes[k * BPW + b]);
            model[(base + k) % DEPTH] = w;
        end
        if (rst_at < 0) begin
            chk("ld_done_pulse", 64'(bus.ld_done), 64'd1);
            chk("busy_at_done",  64'(bus.busy),    64'd1);
            chk("ready_at_done", 64'(bus.ld_ready), 64'd0);
            @(negedge clk);
            chk("ld_done_cleared", 64'(bus.ld_done), 64'd0);
            chk("busy_after_done", 64'(bus.busy),    64'd0);
            chk("no_read_after_load", 64'(bus.rd_valid), 64'd0);
        end else begin
            rst = 1'b1;
            @(negedge clk);
            check_idle_outputs("mid_load_rst");
            rst = 1'b0;
            @(negedge clk);
            chk("no_ld_done_after_rst", 64'(bus.ld_done), 64'd0);
        end
    endtask

    task automatic do_read(input int base, input int len);
        logic [WIDTH-1:0] last_w = '0;
        got.delete();
        @(negedge clk);
        bus.rd_start = 1'b1; bus.rd_base = 4'(base); bus.rd_len = 5'(len);
        @(posedge clk);
        @(negedge clk);
        bus.rd_start = 1'b0;
        chk("rd_busy_start", 64'(bus.busy),     64'd1);
        chk("rd_lat0",       64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        chk("rd_lat1",       64'(bus.rd_valid), 64'd0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            last_w = model[(base + i) % DEPTH];
            chk("rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("rd_data",  64'(bus.rd_data),  64'(last_w));
            chk("rd_last",  64'(bus.rd_last),  64'(i == len - 1));
            got.push_back(bus.rd_data);
        end
        @(negedge clk);
        chk("rd_valid_end", 64'(bus.rd_valid), 64'd0);
        chk("rd_data_hold", 64'(bus.rd_data),  64'(last_w));
        chk("rd_busy_tail", 64'(bus.busy),     64'd1);
        @(negedge clk);
        chk("rd_busy_clear", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_len = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.rd_start = 1'b0; bus.rd_base = '0; bus.rd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // populate the whole buffer with random words
        fill_bytes(DEPTH * BPW, 1'b0);
        do_load(0, DEPTH, 1'b0, -1, 1'b0);

        // counting pattern with fixed expected words
        fill_bytes(2 * BPW, 1'b1);
        do_load(0, 2, 1'b0, -1, 1'b0);
        do_read(0, 2);
        chk("const_word0", got[0], 64'h0102030405060708);
        chk("const_word1", got[1], 64'h090A0B0C0D0E0F10);

        // wrap at DEPTH-1; word at 1 must be untouched
        fill_bytes(2 * BPW, 1'b0);
        do_load(DEPTH - 1, 2, 1'b0, -1, 1'b0);
        do_read(DEPTH - 1, 3);

        // gapped 4-word load, with a simultaneous rd_start that must lose
        fill_bytes(4 * BPW, 1'b0);
        do_load(4, 4, 1'b1, -1, 1'b1);
        do_read(4, 4);

        // zero-length starts are ignored
        @(negedge clk);
        bus.ld_start = 1'b1; bus.ld_len = '0; bus.rd_start = 1'b1; bus.rd_len = '0;
        @(negedge clk);
        bus.ld_start = 1'b0; bus.rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("zero_len_busy",     64'(bus.busy),     64'd0);
            chk("zero_len_ready",    64'(bus.ld_ready), 64'd0);
            chk("zero_len_rd_valid", 64'(bus.rd_valid), 64'd0);
            @(negedge clk);
        end

        // reset after 5 bytes of word 1 in a 3-word load
        fill_bytes(3 * BPW, 1'b0);
        do_load(8, 3, 1'b0, BPW + 5, 1'b0);
        do_read(8, 3);

        // random bursts
        for (int r = 0; r < 6; r++) do_read($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
